// File: rtl/dp_ctrl_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit datapath.
// Drives PC, register, ALU and RAM controls; a watchdog bounds the wait on dp_done.
module dp_ctrl_unit #(
    parameter int DWIDTH  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DWIDTH-1:0] instr,
    input  logic              dp_done,
    input  logic              pc_jump,
    output logic              en_pc_pulse,
    output logic [1:0]        pc_ctrl,
    output logic [7:0]        offset_addr,
    output logic [7:0]        offset,
    output logic [1:0]        rd,
    output logic [1:0]        rs,
    output logic [3:0]        reg_en,
    output logic              dp_en,
    output logic              alu_in_sel,
    output logic [2:0]        alu_func,
    output logic              ram_en,
    output logic              ram_we,
    output logic              busy,
    output logic              halted,
    output logic              error,
    output logic [7:0]        jump_cnt
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_ADDI  = 4'd5;
    localparam logic [3:0] OP_LOAD  = 4'd6;
    localparam logic [3:0] OP_STORE = 4'd7;
    localparam logic [3:0] OP_JMP   = 4'd8;
    localparam logic [3:0] OP_HALT  = 4'd15;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_MEM,
        S_NEXT,
        S_HALT,
        S_ERROR
    } state_t;

    state_t            state_reg, state_next;
    logic [15:0]       ir_reg, ir_next;
    logic [WD_W-1:0]   wd_reg, wd_next;
    logic [7:0]        jump_cnt_reg;
    logic              jump_seen_reg;
    logic              after_next_reg;

    logic [15:0]       cur_ir;
    logic [3:0]        opcode;
    logic [1:0]        rd_field;
    logic [1:0]        rs_field;
    logic [7:0]        imm_field;
    logic [3:0]        rd_onehot;
    logic              is_alu;
    logic              in_window;
    logic              jump_window;

    // The IR is only written at the end of DECODE, so DECODE itself reads the ROM word directly.
    assign cur_ir    = (state_reg == S_DECODE) ? instr[15:0] : ir_reg;
    assign opcode    = cur_ir[15:12];
    assign rd_field  = cur_ir[11:10];
    assign rs_field  = cur_ir[9:8];
    assign imm_field = cur_ir[7:0];
    assign is_alu    = (opcode >= OP_ADD) && (opcode <= OP_ADDI);

    assign in_window = (state_reg == S_DECODE) || (state_reg == S_EXEC) ||
                       (state_reg == S_WB)     || (state_reg == S_MEM)  ||
                       (state_reg == S_NEXT);

    for (genvar gi = 0; gi < 4; gi++) begin : g_rd_dec
        assign rd_onehot[gi] = (rd_field == 2'(gi));
    end

    // A taken jump may be reported in NEXT or the FETCH right after it; count it once.
    assign jump_window = (state_reg == S_NEXT) || ((state_reg == S_FETCH) && after_next_reg);
    assign jump_cnt    = jump_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            ir_reg         <= '0;
            wd_reg         <= '0;
            jump_cnt_reg   <= '0;
            jump_seen_reg  <= 1'b0;
            after_next_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ir_reg         <= ir_next;
            wd_reg         <= wd_next;
            after_next_reg <= (state_reg == S_NEXT);
            if (jump_window && pc_jump && !jump_seen_reg) begin
                jump_cnt_reg  <= jump_cnt_reg + 8'd1;
                jump_seen_reg <= 1'b1;
            end else if (state_reg == S_DECODE) begin
                jump_seen_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        ir_next     = ir_reg;
        wd_next     = wd_reg;
        en_pc_pulse = 1'b0;
        pc_ctrl     = 2'd0;
        offset_addr = 8'd0;
        offset      = 8'd0;
        rd          = 2'd0;
        rs          = 2'd0;
        reg_en      = 4'd0;
        dp_en       = 1'b0;
        alu_in_sel  = 1'b0;
        alu_func    = 3'd0;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        busy        = 1'b1;
        halted      = 1'b0;
        error       = 1'b0;

        if (in_window) begin
            offset      = imm_field;
            offset_addr = imm_field;
            rd          = rd_field;
            rs          = rs_field;
            if ((opcode >= OP_ADD) && (opcode <= OP_OR)) begin
                alu_func = 3'(opcode - 4'd1);
            end
            alu_in_sel = (opcode == OP_ADDI);
        end

        case (state_reg)
            S_IDLE, S_HALT, S_ERROR: begin
                busy   = 1'b0;
                halted = (state_reg == S_HALT);
                error  = (state_reg == S_ERROR);
                if (start) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_DECODE;
            end
            S_DECODE: begin
                ir_next = instr[15:0];
                wd_next = '0;
                if (is_alu) begin
                    state_next = S_EXEC;
                end else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
                    state_next = S_MEM;
                end else if (opcode == OP_HALT) begin
                    state_next = S_HALT;
                end else begin
                    state_next = S_NEXT;
                end
            end
            S_EXEC: begin
                dp_en = (wd_reg == '0);
                // dp_done on the final watchdog cycle still completes the instruction.
                if (dp_done) begin
                    state_next = S_WB;
                end else if (wd_reg == WD_W'(TIMEOUT - 1)) begin
                    state_next = S_ERROR;
                end else begin
                    wd_next = wd_reg + WD_W'(1);
                end
            end
            S_WB: begin
                reg_en     = rd_onehot;
                dp_en      = 1'b1;
                state_next = S_NEXT;
            end
            S_MEM: begin
                ram_en = 1'b1;
                if (opcode == OP_LOAD) begin
                    reg_en = rd_onehot;
                    dp_en  = 1'b1;
                end else begin
                    ram_we = 1'b1;
                end
                state_next = S_NEXT;
            end
            S_NEXT: begin
                en_pc_pulse = 1'b1;
                pc_ctrl     = (opcode == OP_JMP) ? 2'd2 : 2'd1;
                state_next  = S_FETCH;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dp_ctrl_unit.sv
// Bench for dp_ctrl_unit: ROM + PC model feed instructions, a responder answers dp_en,
// and a monitor pops hand-computed expected control snapshots from a scoreboard queue.
module tb_dp_ctrl_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] instr;
    logic        dp_done;
    logic        pc_jump;
    logic        en_pc_pulse;
    logic [1:0]  pc_ctrl;
    logic [7:0]  offset_addr;
    logic [7:0]  offset;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [3:0]  reg_en;
    logic        dp_en;
    logic        alu_in_sel;
    logic [2:0]  alu_func;
    logic        ram_en;
    logic        ram_we;
    logic        busy;
    logic        halted;
    logic        error;
    logic [7:0]  jump_cnt;

    dp_ctrl_unit #(.DWIDTH(16), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .instr       (instr),
        .dp_done     (dp_done),
        .pc_jump     (pc_jump),
        .en_pc_pulse (en_pc_pulse),
        .pc_ctrl     (pc_ctrl),
        .offset_addr (offset_addr),
        .offset      (offset),
        .rd          (rd),
        .rs          (rs),
        .reg_en      (reg_en),
        .dp_en       (dp_en),
        .alu_in_sel  (alu_in_sel),
        .alu_func    (alu_func),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .busy        (busy),
        .halted      (halted),
        .error       (error),
        .jump_cnt    (jump_cnt)
    );

    typedef struct packed {
        logic       en_pc;
        logic [1:0] pc_ctrl;
        logic [7:0] oaddr;
        logic [7:0] off;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [3:0] reg_en;
        logic       dp_en;
        logic       sel;
        logic [2:0] func;
        logic       ram_en;
        logic       ram_we;
        logic       busy;
        logic       halted;
        logic       error;
        logic [7:0] jcnt;
    } obs_t;

    typedef struct {
        obs_t  o;
        int    lat;
        string name;
    } ev_t;

    ev_t         exp_q[$];
    logic [15:0] rom [256];
    int          delay_rom [256];
    logic [7:0]  pc;
    int          cyc;
    int          checks;
    int          failures;
    int          idle_req;
    string       idle_name;
    int          tmo_req;
    string       tmo_name;
    bit          stim_done;

    assign instr = rom[pc];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            pc <= 8'd0;
        end else if (en_pc_pulse) begin
            pc <= (pc_ctrl == 2'd2) ? offset_addr : pc + 8'd1;
        end
    end

    function automatic obs_t mk(input logic en, input logic [1:0] pcc, input logic [7:0] imm,
                                input logic [1:0] r_d, input logic [1:0] r_s, input logic [3:0] ren,
                                input logic dpe, input logic sel, input logic [2:0] fn,
                                input logic rme, input logic rwe, input logic bsy,
                                input logic hlt, input logic err, input logic [7:0] jc);
        obs_t o;
        o.en_pc   = en;
        o.pc_ctrl = pcc;
        o.oaddr   = imm;
        o.off     = imm;
        o.rd      = r_d;
        o.rs      = r_s;
        o.reg_en  = ren;
        o.dp_en   = dpe;
        o.sel     = sel;
        o.func    = fn;
        o.ram_en  = rme;
        o.ram_we  = rwe;
        o.busy    = bsy;
        o.halted  = hlt;
        o.error   = err;
        o.jcnt    = jc;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.en_pc   = en_pc_pulse;
        o.pc_ctrl = pc_ctrl;
        o.oaddr   = offset_addr;
        o.off     = offset;
        o.rd      = rd;
        o.rs      = rs;
        o.reg_en  = reg_en;
        o.dp_en   = dp_en;
        o.sel     = alu_in_sel;
        o.func    = alu_func;
        o.ram_en  = ram_en;
        o.ram_we  = ram_we;
        o.busy    = busy;
        o.halted  = halted;
        o.error   = error;
        o.jcnt    = jump_cnt;
        return o;
    endfunction

    task automatic push(input string nm, input obs_t o, input int lat);
        ev_t e;
        e.o    = o;
        e.lat  = lat;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Datapath stand-in: dp_done after delay_rom[pc] further EXEC cycles (0 = never),
    // pc_jump held through NEXT and the following FETCH for every jump.
    initial begin
        int cnt;
        int jhold;
        cnt     = 0;
        jhold   = 0;
        dp_done = 1'b0;
        pc_jump = 1'b0;
        forever begin
            @(negedge clk);
            dp_done = 1'b0;
            if (rst) begin
                cnt     = 0;
                jhold   = 0;
                pc_jump = 1'b0;
            end else begin
                if (cnt > 0) begin
                    cnt = cnt - 1;
                    if (cnt == 0) dp_done = 1'b1;
                end
                if (dp_en && reg_en == 4'd0 && !ram_en) cnt = delay_rom[pc];
                if (en_pc_pulse && pc_ctrl == 2'd2) jhold = 2;
                pc_jump = (jhold > 0);
                if (jhold > 0) jhold = jhold - 1;
            end
        end
    end

    // Monitor: one scoreboard pop per observed strobe / halt / error transaction.
    initial begin
        obs_t cur;
        ev_t  e;
        int   anchor;
        int   idle_seen;
        int   tmo_seen;
        int   lat;
        logic error_q;
        logic halted_q;
        logic trig;
        anchor    = 0;
        idle_seen = 0;
        tmo_seen  = 0;
        error_q   = 1'b0;
        halted_q  = 1'b0;
        forever begin
            @(negedge clk);
            cur = sample();
            if (start) anchor = cyc;
            trig = en_pc_pulse || (reg_en != 4'd0) || ram_we ||
                   (error && !error_q) || (halted && !halted_q);
            error_q  = error;
            halted_q = halted;
            if (trig) begin
                lat = cyc - anchor;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event act=%h required=none", cur);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (cur !== e.o) begin
                        failures++;
                        $display("FAIL %s act=%h required=%h", e.name, cur, e.o);
                    end
                    checks++;
                    if (lat != e.lat) begin
                        failures++;
                        $display("FAIL %s_latency act=%0d required=%0d", e.name, lat, e.lat);
                    end
                    $display("[tb] cyc=%0d ev=%s lat=%0d obs=%h", cyc, e.name, lat, cur);
                end
                if (en_pc_pulse) anchor = cyc;
            end
            if (idle_req != idle_seen) begin
                idle_seen = idle_req;
                checks++;
                if (cur !== mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
                    failures++;
                    $display("FAIL %s act=%h required=0", idle_name, cur);
                end
                $display("[tb] cyc=%0d idle_check=%s obs=%h", cyc, idle_name, cur);
            end
            if (tmo_req != tmo_seen) begin
                tmo_seen = tmo_req;
                checks++;
                failures++;
                $display("FAIL %s act=timeout required=event", tmo_name);
            end
            if (stim_done || cyc > 20000) begin
                checks++;
                if (exp_q.size() != 0 || !stim_done) begin
                    failures++;
                    $display("FAIL drain act=%0d pending done=%0d required=0 pending done=1",
                             exp_q.size(), stim_done);
                end
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_sig(input int which, input int budget, input string nm);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < budget && !hit; n++) begin
            @(negedge clk);
            case (which)
                0:       hit = halted;
                1:       hit = error;
                default: hit = (pc == 8'h48) && dp_en && (reg_en == 4'd0);
            endcase
        end
        if (!hit) begin
            tmo_name = nm;
            tmo_req++;
        end
    endtask

    initial begin
        cyc       = 0;
        checks    = 0;
        failures  = 0;
        idle_req  = 0;
        tmo_req   = 0;
        stim_done = 1'b0;
        idle_name = "";
        tmo_name  = "";
        rst       = 1'b1;
        start     = 1'b1;
        for (int i = 0; i < 256; i++) begin
            rom[i]       = 16'hF000;
            delay_rom[i] = 0;
        end
        rom[8'h00] = 16'h1600; delay_rom[8'h00] = 1;
        rom[8'h01] = 16'h5005; delay_rom[8'h01] = 3;
        rom[8'h02] = 16'h8042;
        rom[8'h42] = 16'h7300;
        rom[8'h43] = 16'h6800;
        rom[8'h44] = 16'h0000;
        rom[8'h45] = 16'h9ABC;
        rom[8'h46] = 16'h2D00; delay_rom[8'h46] = 1;
        rom[8'h47] = 16'hF000;
        rom[8'h48] = 16'h4400;

        // Reset held two cycles with start high: start must be ignored.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b0;
        idle_name = "reset_state";
        idle_req++;
        repeat (3) @(posedge clk);
        #1 idle_name = "idle_after_reset";
        idle_req++;

        push("add_wb",     mk(1'b0, 2'd0, 8'h00, 2'd1, 2'd2, 4'b0010, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0), 5);
        push("add_next",   mk(1'b1, 2'd1, 8'h00, 2'd1, 2'd2, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0), 6);
        push("addi_wb",    mk(1'b0, 2'd0, 8'h05, 2'd0, 2'd0, 4'b0001, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0), 7);
        push("addi_next",  mk(1'b1, 2'd1, 8'h05, 2'd0, 2'd0, 4'b0000, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0), 8);
        push("jmp_next",   mk(1'b1, 2'd2, 8'h42, 2'd0, 2'd0, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0), 3);
        push("store_mem",  mk(1'b0, 2'd0, 8'h00, 2'd0, 2'd3, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1), 3);
        push("store_next", mk(1'b1, 2'd1, 8'h00, 2'd0, 2'd3, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1), 4);
        push("load_mem",   mk(1'b0, 2'd0, 8'h00, 2'd2, 2'd0, 4'b0100, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1), 3);
        push("load_next",  mk(1'b1, 2'd1, 8'h00, 2'd2, 2'd0, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1), 4);
        push("nop_next",   mk(1'b1, 2'd1, 8'h00, 2'd0, 2'd0, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1), 3);
        push("undef_next", mk(1'b1, 2'd1, 8'hBC, 2'd2, 2'd2, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1), 3);
        push("sub_wb",     mk(1'b0, 2'd0, 8'h00, 2'd3, 2'd1, 4'b1000, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1), 5);
        push("sub_next",   mk(1'b1, 2'd1, 8'h00, 2'd3, 2'd1, 4'b0000, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1), 6);
        push("halt",       mk(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1), 3);
        pulse_start();
        wait_sig(0, 300, "wait_halt");
        repeat (5) @(posedge clk);

        // Restart from HALT on an ADD whose dp_done never comes: watchdog trips.
        #1 rom[8'h47] = 16'h1400;
        delay_rom[8'h47] = 0;
        push("wd_error", mk(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1), 18);
        pulse_start();
        wait_sig(1, 100, "wait_error");
        repeat (3) @(posedge clk);

        // dp_done on the 15th EXEC cycle must still complete.
        #1 rom[8'h47] = 16'h3B00;
        delay_rom[8'h47] = 14;
        push("and_wb",   mk(1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 4'b0100, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1), 18);
        push("and_next", mk(1'b1, 2'd1, 8'h00, 2'd2, 2'd3, 4'b0000, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1), 19);
        pulse_start();

        // Next instruction (OR) stalls in EXEC; reset lands mid-instruction.
        wait_sig(2, 100, "wait_or_exec");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle_name = "reset_mid_exec";
        idle_req++;
        repeat (5) @(posedge clk);
        #1 stim_done = 1'b1;
    end

endmodule
